// File: rtl/fxp32s_conv_arbiter.sv
// Round-robin arbiter feeding one shared fxp32 -> fxp32s converter.
// Two-entry pipeline: operand register (A) then output register (B).
module fxp32s_conv_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [IDW-1:0]     out_id,
    output logic               out_sat,
    input  logic               clr_cnt,
    output logic [15:0]        sat_cnt
);

    logic            va_q;
    logic [31:0]     da_q;
    logic [IDW-1:0]  ia_q;
    logic [IDW-1:0]  ptr_q;
    logic            ov_q;
    logic [31:0]     od_q;
    logic [IDW-1:0]  oi_q;
    logic            os_q;
    logic [15:0]     cnt_q;
    logic [15:0]     cnt_d;

    logic            adv_a;
    logic            adv_b;
    logic            gnt_vld;
    logic [IDW-1:0]  gnt_idx;
    logic            acc;
    logic [30:0]     neg;
    logic [31:0]     conv;
    logic            conv_sat;

    function automatic logic [IDW-1:0] wrap(input int v);
        if (v >= NREQ) begin
            return IDW'(v - NREQ);
        end
        return IDW'(v);
    endfunction

    assign adv_b = !ov_q || out_ready;
    assign adv_a = !va_q || adv_b;
    assign acc   = gnt_vld && adv_a && rst_n;

    // Cyclic search for the first valid requester starting at ptr.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_vld && req_valid[wrap(int'(ptr_q) + k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = wrap(int'(ptr_q) + k);
            end
        end
    end

    // Only the granted requester sees ready, and only when A can take it.
    always_comb begin
        req_ready = '0;
        if (acc) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign neg = ~da_q[30:0] + 31'd1;

    // Two's complement to sign-magnitude; -2^31 has no positive twin.
    always_comb begin
        conv     = da_q;
        conv_sat = 1'b0;
        if (da_q[31]) begin
            if (da_q[30:0] == 31'd0) begin
                conv     = 32'hFFFF_FFFF;
                conv_sat = 1'b1;
            end else begin
                conv = {1'b1, neg};
            end
        end
    end

    // Operand stage: load on accept, empty when it drains with no accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            va_q  <= 1'b0;
            da_q  <= '0;
            ia_q  <= '0;
            ptr_q <= '0;
        end else if (adv_a) begin
            va_q <= acc;
            if (acc) begin
                da_q  <= req_data[32*gnt_idx +: 32];
                ia_q  <= gnt_idx;
                ptr_q <= wrap(int'(gnt_idx) + 1);
            end
        end
    end

    // Output stage: captures the converted operand whenever it may advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q <= 1'b0;
            od_q <= '0;
            oi_q <= '0;
            os_q <= 1'b0;
        end else if (adv_b) begin
            ov_q <= va_q;
            od_q <= conv;
            oi_q <= ia_q;
            os_q <= conv_sat;
        end
    end

    // Saturating count of delivered saturated results; clear wins.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (ov_q && out_ready && os_q && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_id    = oi_q;
    assign out_sat   = os_q;
    assign sat_cnt   = cnt_q;

endmodule

// File: tb/tb_fxp32s_conv_arbiter.sv
// Bench for fxp32s_conv_arbiter: table vectors, hand sequences and a
// queue-based reference model checked every cycle.
module tb_fxp32s_conv_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic [1:0]   out_id;
    logic         out_sat;
    logic         clr_cnt = 1'b0;
    logic [15:0]  sat_cnt;

    fxp32s_conv_arbiter #(.NREQ(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_id(out_id),
        .out_sat(out_sat),
        .clr_cnt(clr_cnt),
        .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  id;
        bit          fresh;
    } item_t;

    typedef struct {
        int          id;
        logic [31:0] din;
        logic [31:0] dout;
        logic        sat;
    } vec_t;

    int    nerr = 0;
    int    nchk = 0;
    int    ptr_m = 0;
    int    cnt_m = 0;
    item_t q[$];

    logic [3:0]  rr;
    logic        dv;
    logic [1:0]  di;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion by plain signed arithmetic: {sat, data}.
    function automatic logic [32:0] conv_ref(input logic [31:0] d);
        longint v;
        longint mag;
        v = longint'($signed(d));
        if (v >= 0) return {1'b0, d};
        mag = -v;
        if (mag > 64'sd2147483647) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, 1'b1, mag[30:0]};
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'h0000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'hFFFF_FFFF;
            4: return 32'h8000_0001;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [127:0] rnd_vec();
        return {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
    endfunction

    // One clock cycle: drive at negedge, check against model, advance.
    task automatic step(input logic [3:0] v, input logic [127:0] d,
                        input logic ordy, input logic clr,
                        output logic [3:0] rro, output logic dlv,
                        output logic [1:0] did);
        int          j;
        bit          found;
        bit          expv;
        bit          adva;
        bit          acc;
        bit          deliv;
        bit          dsat;
        logic [3:0]  exp_rr;
        logic [32:0] r;
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        out_ready = ordy;
        clr_cnt   = clr;
        #1;
        found = 0;
        j = 0;
        for (int k = 0; k < 4; k++) begin
            if (!found && v[(ptr_m + k) % 4]) begin
                found = 1;
                j = (ptr_m + k) % 4;
            end
        end
        expv = (q.size() > 0) && !(q.size() == 1 && q[0].fresh);
        adva = !(q.size() == 2 && !ordy);
        acc = found && adva;
        exp_rr = acc ? 4'(1 << j) : 4'b0;
        check("req_ready", 32'(req_ready), 32'(exp_rr));
        check("out_valid", 32'(out_valid), 32'(expv));
        dsat = 0;
        if (expv) begin
            r = conv_ref(q[0].data);
            dsat = r[32];
            check("out_data", out_data, r[31:0]);
            check("out_id", 32'(out_id), 32'(q[0].id));
            check("out_sat", 32'(out_sat), 32'(r[32]));
        end
        check("sat_cnt", 32'(sat_cnt), 32'(cnt_m));
        deliv = expv && ordy;
        rro = req_ready;
        dlv = out_valid && out_ready;
        did = out_id;
        @(posedge clk);
        #1;
        if (deliv) void'(q.pop_front());
        foreach (q[i]) q[i].fresh = 0;
        if (clr) cnt_m = 0;
        else if (deliv && dsat && cnt_m < 65535) cnt_m++;
        if (acc) begin
            q.push_back('{d[32*j +: 32], 2'(j), 1'b1});
            ptr_m = (j + 1) % 4;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        q.delete();
        ptr_m = 0;
        cnt_m = 0;
        @(negedge clk);
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t        vt[8];
    logic [3:0]  rrs[6];
    logic [1:0]  ids[6];
    int          eg[6];
    int          n;
    logic [31:0] hold;
    int          dq[$];

    initial begin
        vt[0] = '{0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0};
        vt[1] = '{3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1};
        vt[2] = '{1, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vt[3] = '{2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0};
        vt[4] = '{0, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0};
        vt[5] = '{1, 32'hFFFF_FFFE, 32'h8000_0002, 1'b0};
        vt[6] = '{2, 32'hC000_0000, 32'hC000_0000, 1'b0};
        vt[7] = '{3, 32'h1234_5678, 32'h1234_5678, 1'b0};
        eg = '{0, 1, 2, 3, 0, 1};

        do_reset();

        // Table vectors through an empty pipeline.
        for (int i = 0; i < 8; i++) begin
            step(4'(1 << vt[i].id), {4{vt[i].din}}, 1'b1, 1'b0, rr, dv, di);
            check("vec_accept", 32'(rr), 32'(1 << vt[i].id));
            step(4'h0, rnd_vec(), 1'b1, 1'b0, rr, dv, di);
            check("vec_valid", 32'(out_valid), 32'd1);
            check("vec_data", out_data, vt[i].dout);
            check("vec_id", 32'(out_id), 32'(vt[i].id));
            check("vec_sat", 32'(out_sat), 32'(vt[i].sat));
            step(4'h0, rnd_vec(), 1'b1, 1'b0, rr, dv, di);
        end
        check("vec_sat_cnt", 32'(sat_cnt), 32'd1);

        // Round robin with everyone requesting.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step(4'hF, rnd_vec(), 1'b1, 1'b0, rr, dv, di);
            rrs[c] = rr;
            ids[c] = di;
        end
        for (int c = 0; c < 6; c++) check("rr_grant", 32'(rrs[c]), 32'(1 << eg[c]));
        for (int c = 2; c < 6; c++) check("rr_out_id", 32'(ids[c]), 32'(eg[c-2]));
        step(4'b0010, rnd_vec(), 1'b1, 1'b0, rr, dv, di);
        check("rr_lone_1", 32'(rr), 32'h2);
        step(4'hF, rnd_vec(), 1'b1, 1'b0, rr, dv, di);
        check("rr_ptr_2", 32'(rr), 32'h4);

        // Backpressure: two accepts fill A and B, then everything stalls.
        do_reset();
        n = 0;
        hold = '0;
        for (int c = 0; c < 5; c++) begin
            step(4'hF, rnd_vec(), 1'b0, 1'b0, rr, dv, di);
            if (rr != 4'h0) n++;
            if (c >= 2) begin
                check("bp_ready_low", 32'(rr), 32'd0);
                check("bp_data_hold", out_data, hold);
            end
            if (c == 1) hold = out_data;
        end
        check("bp_accepts", 32'(n), 32'd2);
        dq.delete();
        step(4'hF, rnd_vec(), 1'b1, 1'b0, rr, dv, di);
        check("bp_release_acc", 32'(rr), 32'h4);
        if (dv) dq.push_back(int'(di));
        for (int c = 0; c < 4; c++) begin
            step(4'h0, rnd_vec(), 1'b1, 1'b0, rr, dv, di);
            if (dv) dq.push_back(int'(di));
        end
        check("bp_count", 32'(dq.size()), 32'd3);
        for (int c = 0; c < 3; c++) begin
            if (c < dq.size()) check("bp_order", 32'(dq[c]), 32'(c));
        end

        // Reset while both stages hold data.
        step(4'hF, rnd_vec(), 1'b0, 1'b0, rr, dv, di);
        step(4'hF, rnd_vec(), 1'b0, 1'b0, rr, dv, di);
        check("mid_full", 32'(out_valid), 32'd1);
        #2;
        do_reset();
        step(4'b1010, rnd_vec(), 1'b1, 1'b0, rr, dv, di);
        check("mid_first_grant", 32'(rr), 32'h2);
        step(4'h0, rnd_vec(), 1'b1, 1'b0, rr, dv, di);
        step(4'h0, rnd_vec(), 1'b1, 1'b0, rr, dv, di);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(4'($urandom_range(0, 15)), rnd_vec(),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 49) == 0),
                 rr, dv, di);
        end

        // Counter saturation and clear-over-increment.
        do_reset();
        for (int i = 0; i < 70000 && cnt_m < 65535; i++) begin
            step(4'hF, {4{32'h8000_0000}}, 1'b1, 1'b0, rr, dv, di);
        end
        check("cnt_preload", 32'(sat_cnt), 32'hFFFF);
        step(4'hF, {4{32'h8000_0000}}, 1'b1, 1'b0, rr, dv, di);
        check("cnt_sat_hold", 32'(sat_cnt), 32'hFFFF);
        step(4'hF, {4{32'h8000_0000}}, 1'b1, 1'b1, rr, dv, di);
        check("cnt_clr_wins", 32'(sat_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
